tipi_rpi_shift_master: RTL

//  Serial master for the RPi side of the TIPI CPLD register port. Turns byte

---
 rtl/tipi_rpi_shift_master.sv | 106 ++++++++++
 1 files changed

// File: rtl/tipi_rpi_shift_master.sv
// tipi_rpi_shift_master: serial master driving the TIPI CPLD register port (clk/reset, cmd_* in, rsp_* out, r_* serial pins)
module tipi_rpi_shift_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rt,
  input  logic       cmd_cd,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
);
  localparam logic [7:0] HM1 = 8'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, LOAD_HI, LOAD_LO, SHIFT_HI, SHIFT_LO, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic [7:0] rdata;
  logic [1:0] sync;
  logic last;
  assign last = cnt == 8'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= HM1;
      bit_cnt <= 3'd0;
      sh <= 8'd0;
      rdata <= 8'd0;
      sync <= 2'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      r_clk <= 1'b0;
      r_le <= 1'b0;
      r_rt <= 1'b0;
      r_cd <= 1'b0;
      r_dout <= 1'b0;
    end else begin
      sync <= {sync[0], r_din};
      cnt <= (last || state == IDLE) ? HM1 : cnt - 8'd1;
      case (state)
        IDLE: if (cmd_valid) begin
          state <= SETUP;
          cmd_ready <= 1'b0;
          r_rt <= cmd_rt;
          r_cd <= cmd_cd;
          sh <= cmd_wdata;
          r_dout <= ~cmd_rt & cmd_wdata[7];
          bit_cnt <= 3'd0;
        end
        SETUP: if (last) begin
          state <= r_rt ? LOAD_HI : SHIFT_HI;
          r_clk <= 1'b1;
          r_le <= r_rt;
        end
        LOAD_HI: if (last) begin
          state <= LOAD_LO;
          r_clk <= 1'b0;
        end
        LOAD_LO: if (last) begin
          state <= SHIFT_HI;
          r_clk <= 1'b1;
          r_le <= 1'b0;
        end
        // the next write bit is presented on the falling edge so it is stable at the following rise
        SHIFT_HI: if (last) begin
          state <= SHIFT_LO;
          r_clk <= 1'b0;
          sh <= {sh[6:0], 1'b0};
          r_dout <= ~r_rt & sh[6];
        end
        // read bits are sampled at the very end of the low phase, as late as possible after the rise
        SHIFT_LO: if (last) begin
          if (r_rt) rdata <= {rdata[6:0], sync[1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_rt ? {rdata[6:0], sync[1]} : 8'd0;
            r_dout <= 1'b0;
          end else begin
            state <= SHIFT_HI;
            r_clk <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          r_rt <= 1'b0;
          r_cd <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
